// File: rtl/mc_ctrl.sv
// Multi-cycle control FSM for the MIPS-lite core: sequences fetch/decode/execute/memory/writeback.
// Optional memory handshake: define MCTRL_MEM_WAIT_EN to add mem_ready and memory wait states.
module mc_ctrl #(
  parameter logic [4:0] RA_IDX = 5'd31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] op,
  input  logic [5:0] func,
  input  logic       zero,
`ifdef MCTRL_MEM_WAIT_EN
  input  logic       mem_ready,
`endif
  output logic       pc_wr,
  output logic [1:0] npc_sel,
  output logic       ir_wr,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic [1:0] ext_op,
  output logic [4:0] ra_idx,
  output logic       instr_done,
  output logic       illegal,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_RESET  = 4'd0,  S_FETCH  = 4'd1,  S_DECODE = 4'd2,  S_EXE_R  = 4'd3,
    S_EXE_I  = 4'd4,  S_MEMADR = 4'd5,  S_MEMRD  = 4'd6,  S_MEMWR  = 4'd7,
    S_WB_R   = 4'd8,  S_WB_I   = 4'd9,  S_WB_MEM = 4'd10, S_BRANCH = 4'd11,
    S_JAL    = 4'd12, S_JR     = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    C_NONE, C_ADDU, C_SUBU, C_ORI, C_LUI, C_LW, C_SW
  } cls_t;

  state_t state_q, state_d;
  cls_t   cls_q, dec_cls;
  state_t dec_next;
  logic   dec_done, dec_ill;
  logic   ready;

`ifdef MCTRL_MEM_WAIT_EN
  assign ready = mem_ready;
`else
  assign ready = 1'b1;
`endif

  assign ra_idx = RA_IDX;
  assign state  = state_q;

  always_comb begin
    dec_cls  = C_NONE;
    dec_next = S_FETCH;
    dec_done = 1'b0;
    dec_ill  = 1'b0;
    case (op)
      6'h00: begin
        case (func)
          6'h21: begin dec_cls = C_ADDU; dec_next = S_EXE_R; end
          6'h23: begin dec_cls = C_SUBU; dec_next = S_EXE_R; end
          6'h08: dec_next = S_JR;
          6'h00: dec_done = 1'b1;
          default: dec_ill = 1'b1;
        endcase
      end
      6'h0D: begin dec_cls = C_ORI; dec_next = S_EXE_I; end
      6'h0F: begin dec_cls = C_LUI; dec_next = S_EXE_I; end
      6'h23: begin dec_cls = C_LW;  dec_next = S_MEMADR; end
      6'h2B: begin dec_cls = C_SW;  dec_next = S_MEMADR; end
      6'h04: dec_next = S_BRANCH;
      6'h03: dec_next = S_JAL;
      default: dec_ill = 1'b1;
    endcase
  end

  // The decoded class is captured only in DECODE so IR changes later have no effect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_RESET;
      cls_q   <= C_NONE;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE) cls_q <= dec_cls;
    end
  end

  always_comb begin
    state_d    = S_FETCH;
    pc_wr      = 1'b0;
    npc_sel    = 2'd0;
    ir_wr      = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src    = 1'b0;
    alu_op     = 2'd0;
    ext_op     = 2'd0;
    instr_done = 1'b0;
    illegal    = 1'b0;
    case (state_q)
      S_RESET: state_d = S_FETCH;
      S_FETCH: begin
        mem_rd  = 1'b1;
        ir_wr   = ready;
        pc_wr   = ready;
        state_d = ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        state_d    = dec_next;
        instr_done = dec_done;
        illegal    = dec_ill;
      end
      S_EXE_R, S_WB_R: begin
        alu_op = (cls_q == C_SUBU) ? 2'd1 : 2'd0;
        if (state_q == S_WB_R) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'd1;
          instr_done = 1'b1;
        end else begin
          state_d = S_WB_R;
        end
      end
      S_EXE_I, S_WB_I: begin
        alu_src = 1'b1;
        alu_op  = (cls_q == C_LUI) ? 2'd0 : 2'd2;
        ext_op  = (cls_q == C_LUI) ? 2'd2 : 2'd0;
        if (state_q == S_WB_I) begin
          reg_wr     = 1'b1;
          instr_done = 1'b1;
        end else begin
          state_d = S_WB_I;
        end
      end
      S_MEMADR, S_MEMRD, S_MEMWR: begin
        alu_src = 1'b1;
        ext_op  = 2'd1;
        if (state_q == S_MEMADR) begin
          state_d = (cls_q == C_SW) ? S_MEMWR : S_MEMRD;
        end else if (state_q == S_MEMRD) begin
          mem_rd  = 1'b1;
          state_d = ready ? S_WB_MEM : S_MEMRD;
        end else begin
          mem_wr     = 1'b1;
          instr_done = ready;
          state_d    = ready ? S_FETCH : S_MEMWR;
        end
      end
      S_WB_MEM: begin
        reg_wr     = 1'b1;
        mem_to_reg = 2'd1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        alu_op     = 2'd1;
        ext_op     = 2'd1;
        npc_sel    = 2'd1;
        pc_wr      = zero;
        instr_done = 1'b1;
      end
      // JAL links pc+4 from the pre-write PC; the datapath guarantees the ordering.
      S_JAL: begin
        pc_wr      = 1'b1;
        npc_sel    = 2'd2;
        reg_wr     = 1'b1;
        reg_dst    = 2'd2;
        mem_to_reg = 2'd2;
        instr_done = 1'b1;
      end
      S_JR: begin
        pc_wr      = 1'b1;
        npc_sel    = 2'd3;
        instr_done = 1'b1;
      end
      default: state_d = S_FETCH;
    endcase
  end

endmodule
